// File: rtl/cluster_evt_propagator_tx.sv
// Cluster-side four-phase event transmitter: queues local event pulses in a
// saturating counter and issues one valid/ack handshake per event.
module cluster_evt_propagator_tx #(
    parameter int unsigned CNT_WIDTH   = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 event_i,
    output logic                 valid_o,
    input  logic                 ack_i,
    output logic [CNT_WIDTH-1:0] pending_o,
    output logic                 busy_o,
    output logic                 overflow_o,
    input  logic                 clr_overflow_i
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_REQ     = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    logic [SYNC_STAGES-1:0] ack_sync_q;
    logic                   ack_s;
    logic [1:0]             state_q, state_d;
    logic [CNT_WIDTH-1:0]   pending_q, pending_d;
    logic                   overflow_q, overflow_d;
    logic                   valid_q, busy_q;
    logic                   launch, enter_req;

    assign ack_s  = ack_sync_q[SYNC_STAGES-1];
    assign launch = (pending_q != '0) || event_i;

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case/if leaves it unassigned and infers a latch.
    always_comb begin
        state_d   = state_q;
        enter_req = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // A stale ack still high after reset holds off the launch.
                if (launch && !ack_s) begin
                    state_d   = ST_REQ;
                    enter_req = 1'b1;
                end
            end
            ST_REQ: begin
                if (ack_s) state_d = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (!ack_s) begin
                    if (launch) begin
                        state_d   = ST_REQ;
                        enter_req = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        pending_d  = pending_q;
        overflow_d = overflow_q;
        if (clr_overflow_i) overflow_d = 1'b0;
        if (enter_req) begin
            // Launching consumes one event; an arriving pulse replaces it.
            if ((pending_q != '0) && !event_i) pending_d = pending_q - CNT_ONE;
        end else if (event_i) begin
            if (pending_q == CNT_MAX) overflow_d = 1'b1;
            else                      pending_d  = pending_q + CNT_ONE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge value of its neighbours regardless of block order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ack_sync_q <= '0;
            state_q    <= ST_IDLE;
            pending_q  <= '0;
            overflow_q <= 1'b0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], ack_i};
            state_q    <= state_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
            // Decoded outputs are registered so valid_o has no input-to-output path.
            valid_q    <= (state_d == ST_REQ);
            busy_q     <= (state_d != ST_IDLE);
        end
    end

    assign valid_o    = valid_q;
    assign busy_o     = busy_q;
    assign pending_o  = pending_q;
    assign overflow_o = overflow_q;

endmodule

// File: tb/tb_cluster_evt_propagator_tx.sv
// Directed bench for cluster_evt_propagator_tx: a per-cycle vector table plus
// hand-written burst, saturation, reset and ack-noise sequences.
module tb_cluster_evt_propagator_tx;

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic       event_i = 1'b0;
    logic       ack_i = 1'b0;
    logic       clr_overflow_i = 1'b0;
    logic       valid_o;
    logic [3:0] pending_o;
    logic       busy_o;
    logic       overflow_o;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic       ev;
        logic       ack;
        logic       clr;
        logic       exp_valid;
        logic       exp_busy;
        logic [3:0] exp_pend;
        logic       exp_ovf;
    } vec_t;

    vec_t vecs[$];

    cluster_evt_propagator_tx #(.CNT_WIDTH(4), .SYNC_STAGES(2)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .event_i        (event_i),
        .valid_o        (valid_o),
        .ack_i          (ack_i),
        .pending_o      (pending_o),
        .busy_o         (busy_o),
        .overflow_o     (overflow_o),
        .clr_overflow_i (clr_overflow_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        event_i        = 1'b0;
        ack_i          = 1'b0;
        clr_overflow_i = 1'b0;
        rst_ni         = 1'b0;
        tick();
        tick();
        rst_ni = 1'b1;
    endtask

    task automatic add(input logic ev, input logic ack, input logic clr, input logic v,
                       input logic b, input logic [3:0] p, input logic o);
        vec_t t;
        t.ev = ev; t.ack = ack; t.clr = clr;
        t.exp_valid = v; t.exp_busy = b; t.exp_pend = p; t.exp_ovf = o;
        vecs.push_back(t);
    endtask

    task automatic run_table();
        //   ev ack clr   valid busy pend ovf
        add(1, 0, 0,   1, 1, 4'd0, 0);  // single event launches directly
        add(0, 0, 0,   1, 1, 4'd0, 0);
        add(0, 0, 0,   1, 1, 4'd0, 0);
        add(0, 1, 0,   1, 1, 4'd0, 0);  // ack_i rises
        add(0, 1, 0,   1, 1, 4'd0, 0);
        add(0, 1, 0,   0, 1, 4'd0, 0);  // valid falls SYNC_STAGES+1 edges later
        add(0, 0, 0,   0, 1, 4'd0, 0);  // ack_i drops
        add(0, 0, 0,   0, 1, 4'd0, 0);
        add(0, 0, 0,   0, 0, 4'd0, 0);  // back to IDLE once ack_s is low
        add(1, 0, 1,   1, 1, 4'd0, 0);  // clear with nothing set is harmless
        add(1, 0, 0,   1, 1, 4'd1, 0);
        add(1, 0, 0,   1, 1, 4'd2, 0);
        add(1, 0, 0,   1, 1, 4'd3, 0);
        add(0, 1, 0,   1, 1, 4'd3, 0);
        add(0, 1, 0,   1, 1, 4'd3, 0);
        add(0, 1, 0,   0, 1, 4'd3, 0);  // RELEASE with pending 3
        add(0, 0, 0,   0, 1, 4'd3, 0);
        add(0, 0, 0,   0, 1, 4'd3, 0);
        add(1, 0, 0,   1, 1, 4'd3, 0);  // ack_s falls with event_i: REQ, pending holds
        add(0, 0, 0,   1, 1, 4'd3, 0);
        for (int i = 0; i < vecs.size(); i++) begin
            event_i        = vecs[i].ev;
            ack_i          = vecs[i].ack;
            clr_overflow_i = vecs[i].clr;
            tick();
            check($sformatf("vec%0d valid", i), valid_o,    vecs[i].exp_valid);
            check($sformatf("vec%0d busy", i),  busy_o,     vecs[i].exp_busy);
            check($sformatf("vec%0d pend", i),  pending_o,  vecs[i].exp_pend);
            check($sformatf("vec%0d ovf", i),   overflow_o, vecs[i].exp_ovf);
        end
        event_i = 1'b0; ack_i = 1'b0; clr_overflow_i = 1'b0;
    endtask

    task automatic seq_burst();
        int   rises = 0, peak = 0, idle_gap = 0, cnt = 0, cyc = 0;
        logic prev_valid = 1'b0;
        do_reset();
        while (cyc < 600 && !(rises == 5 && !busy_o)) begin
            event_i = (cyc < 5);
            if (valid_o) begin
                cnt++;
                if (cnt >= 10) ack_i = 1'b1;
            end else begin
                cnt   = 0;
                ack_i = 1'b0;
            end
            tick();
            if (valid_o && !prev_valid) rises++;
            prev_valid = valid_o;
            if (int'(pending_o) > peak) peak = int'(pending_o);
            if (rises > 0 && rises < 5 && !busy_o) idle_gap++;
            cyc++;
        end
        event_i = 1'b0; ack_i = 1'b0;
        check("burst finished in budget", busy_o, 1'b0);
        check("burst valid rises", rises, 5);
        check("burst pending peak", peak, 4);
        check("burst idle gaps", idle_gap, 0);
        check("burst pending end", pending_o, 4'd0);
    endtask

    task automatic seq_saturation();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            event_i = 1'b1;
            tick();
        end
        event_i = 1'b0;
        check("sat pending", pending_o, 4'd15);
        check("sat overflow", overflow_o, 1'b1);
        check("sat valid held", valid_o, 1'b1);
        tick(); tick(); tick();
        check("sat overflow sticky", overflow_o, 1'b1);
        clr_overflow_i = 1'b1;
        tick();
        clr_overflow_i = 1'b0;
        check("sat overflow cleared", overflow_o, 1'b0);
        check("sat pending after clr", pending_o, 4'd15);
        clr_overflow_i = 1'b1;
        event_i        = 1'b1;
        tick();
        clr_overflow_i = 1'b0;
        event_i        = 1'b0;
        check("sat set beats clr", overflow_o, 1'b1);
        check("sat pending stays max", pending_o, 4'd15);
    endtask

    task automatic seq_reset_mid();
        do_reset();
        event_i = 1'b1;
        tick(); tick(); tick();
        event_i = 1'b0;
        ack_i   = 1'b1;
        tick();
        check("rst pre valid", valid_o, 1'b1);
        check("rst pre pending", pending_o, 4'd2);
        #2;
        rst_ni = 1'b0;
        #1;
        check("rst async valid", valid_o, 1'b0);
        check("rst async busy", busy_o, 1'b0);
        check("rst async pending", pending_o, 4'd0);
        check("rst async overflow", overflow_o, 1'b0);
        tick();
        rst_ni = 1'b1;
        tick(); tick();
        event_i = 1'b1;
        tick();
        event_i = 1'b0;
        check("stale ack valid", valid_o, 1'b0);
        check("stale ack busy", busy_o, 1'b0);
        check("stale ack pending", pending_o, 4'd1);
        tick(); tick();
        check("stale ack holds", valid_o, 1'b0);
        ack_i = 1'b0;
        tick(); tick();
        check("ack clearing still idle", valid_o, 1'b0);
        tick();
        check("launch after ack clears", valid_o, 1'b1);
        check("launch consumes pending", pending_o, 4'd0);
    endtask

    task automatic seq_idle_noise();
        do_reset();
        for (int i = 0; i < 40; i++) begin
            ack_i = 1'($urandom_range(0, 1));
            tick();
            check($sformatf("noise%0d outputs", i),
                  {valid_o, busy_o, pending_o, overflow_o}, 7'd0);
        end
        ack_i = 1'b0;
    endtask

    initial begin
        do_reset();
        check("reset valid", valid_o, 1'b0);
        check("reset busy", busy_o, 1'b0);
        check("reset pending", pending_o, 4'd0);
        check("reset overflow", overflow_o, 1'b0);
        run_table();
        seq_burst();
        seq_saturation();
        seq_reset_mid();
        seq_idle_noise();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
